// File: rtl/led_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : led_frame_loader
// Description : Serial-to-parallel write controller for a bank of dff_dis_led
//               cells. Collects WIDTH data bits then WIDTH mask bits (both
//               MSB-first) over a one-bit valid/ready stream, then opens the
//               bank's per-cell load enables for exactly one clock edge so
//               only the masked cells take the new data.
// Ports       : clk_i        - clock shared with the LED bank
//               rst_i        - synchronous active-high reset
//               start_i      - begin or restart a frame
//               sdi_i        - serial data bit
//               sdi_valid_i  - sdi_i is valid this cycle
//               sdi_ready_o  - loader accepts a bit this cycle
//               busy_o       - a frame is in progress (not IDLE)
//               done_o       - one-cycle pulse during COMMIT
//               d_o          - per-cell data to the bank
//               dis_o        - per-cell disable to the bank (1 = hold)
// Revision    : 1.0 - initial release
// ============================================================================
module led_frame_loader #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             sdi_i,
    input  logic             sdi_valid_i,
    output logic             sdi_ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] d_o,
    output logic [WIDTH-1:0] dis_o
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_MASK   = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [WIDTH-1:0] mask_q,  mask_d;

    logic             accept;

    // Ready is decoded from state only, so acceptance never depends on a
    // combinational path from the stream inputs to the outputs.
    assign accept = sdi_valid_i & ((state_q == S_DATA) | (state_q == S_MASK));

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        mask_d  = mask_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end

            S_DATA, S_MASK: begin
                if (start_i) begin
                    // Restart wins over a bit arriving in the same cycle;
                    // that bit is discarded and old register contents are
                    // simply overwritten by the new frame's shifting.
                    state_d = S_DATA;
                    cnt_d   = '0;
                end else if (accept) begin
                    if (state_q == S_DATA) begin
                        data_d = {data_q[WIDTH-2:0], sdi_i};
                    end else begin
                        mask_d = {mask_q[WIDTH-2:0], sdi_i};
                    end

                    if (cnt_q == C_LAST) begin
                        cnt_d   = '0;
                        state_d = (state_q == S_DATA) ? S_MASK : S_COMMIT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_COMMIT: begin
                // start_i is deliberately not looked at here
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registers only
    // ------------------------------------------------------------------
    always_comb begin
        sdi_ready_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        dis_o       = '1;
        d_o         = data_q;

        case (state_q)
            S_DATA, S_MASK: begin
                sdi_ready_o = 1'b1;
                busy_o      = 1'b1;
            end
            S_COMMIT: begin
                busy_o = 1'b1;
                done_o = 1'b1;
                dis_o  = ~mask_q;
            end
            default: begin
                sdi_ready_o = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_led_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_frame_loader
// Description : Directed self-checking bench for led_frame_loader (WIDTH=8)
//               with a behavioural model of the downstream dff_dis_led bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_frame_loader;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             start_i = 1'b0;
    logic             sdi_i = 1'b0;
    logic             sdi_valid_i = 1'b0;
    logic             sdi_ready_o;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] d_o;
    logic [WIDTH-1:0] dis_o;

    // bank model
    logic             bank_load = 1'b0;
    logic [WIDTH-1:0] bank_val  = '0;
    logic [WIDTH-1:0] bank_q;

    int n_cmp  = 0;
    int n_err  = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    led_frame_loader #(.WIDTH(WIDTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .sdi_i       (sdi_i),
        .sdi_valid_i (sdi_valid_i),
        .sdi_ready_o (sdi_ready_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .d_o         (d_o),
        .dis_o       (dis_o)
    );

    // dff_dis_led bank: each cell loads d when its disable is low
    always_ff @(posedge clk) begin
        if (bank_load) begin
            bank_q <= bank_val;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!dis_o[i]) bank_q[i] <= d_o[i];
            end
        end
    end

    always @(negedge clk) begin
        if (done_o === 1'b1) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [WIDTH-1:0] v);
        bank_val  = v;
        bank_load = 1'b1;
        step();
        bank_load = 1'b0;
    endtask

    // start in current cycle, then 16 bits with valid held high; returns
    // positioned in the COMMIT cycle (cycle 17 relative to start)
    task automatic frame(input logic [WIDTH-1:0] dat, input logic [WIDTH-1:0] msk);
        logic [2*WIDTH-1:0] bits;
        bits = {dat, msk};
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 2*WIDTH-1; i >= 0; i--) begin
            sdi_i       = bits[i];
            sdi_valid_i = 1'b1;
            step();
        end
        sdi_valid_i = 1'b0;
        sdi_i       = 1'b0;
    endtask

    initial begin
        logic [2*WIDTH-1:0] bits;
        int                 idx;
        int                 budget;
        logic [WIDTH-1:0]   dis_seen;

        // ---------------- reset state ----------------
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        chk("rst_dis",   16'(dis_o), 16'h00FF);
        chk("rst_d",     16'(d_o), 16'h0000);
        chk("rst_busy",  16'(busy_o), 16'h0);
        chk("rst_ready", 16'(sdi_ready_o), 16'h0);
        chk("rst_done",  16'(done_o), 16'h0);

        // ---------------- reset during MASK ----------------
        preload(8'h55);
        done_cnt = 0;
        start_i  = 1'b1;
        step();
        start_i = 1'b0;
        bits = 16'hA5F0;
        for (int i = 15; i >= 5; i--) begin
            sdi_i       = bits[i];
            sdi_valid_i = 1'b1;
            step();
        end
        chk("mid_mask_ready", 16'(sdi_ready_o), 16'h1);
        rst_i = 1'b1;
        step();
        step();
        rst_i       = 1'b0;
        sdi_valid_i = 1'b0;
        chk("abort_dis",   16'(dis_o), 16'h00FF);
        chk("abort_d",     16'(d_o), 16'h0000);
        chk("abort_busy",  16'(busy_o), 16'h0);
        chk("abort_ready", 16'(sdi_ready_o), 16'h0);
        step();
        step();
        chk("abort_nodone", 16'(done_cnt), 16'd0);
        chk("abort_bank",   16'(bank_q), 16'h0055);

        // ---------------- full write A5 / FF ----------------
        done_cnt = 0;
        start_i  = 1'b1;
        step();
        start_i = 1'b0;
        chk("c1_ready", 16'(sdi_ready_o), 16'h1);
        chk("c1_busy",  16'(busy_o), 16'h1);
        bits = 16'hA5FF;
        for (int i = 15; i >= 0; i--) begin
            sdi_i       = bits[i];
            sdi_valid_i = 1'b1;
            step();
        end
        sdi_valid_i = 1'b0;
        chk("full_done",  16'(done_o), 16'h1);
        chk("full_dis",   16'(dis_o), 16'h0000);
        chk("full_d",     16'(d_o), 16'h00A5);
        chk("full_ready", 16'(sdi_ready_o), 16'h0);
        step();
        chk("full_bank",   16'(bank_q), 16'h00A5);
        chk("full_done_1", 16'(done_o), 16'h0);
        chk("full_idle",   16'(busy_o), 16'h0);
        chk("full_dcnt",   16'(done_cnt), 16'd1);

        // ---------------- partial mask ----------------
        preload(8'h00);
        frame(8'hFF, 8'h0F);
        chk("part_dis",  16'(dis_o), 16'h00F0);
        chk("part_done", 16'(done_o), 16'h1);
        step();
        chk("part_bank", 16'(bank_q), 16'h000F);

        // ---------------- stalls ----------------
        done_cnt = 0;
        start_i  = 1'b1;
        step();
        start_i = 1'b0;
        bits   = 16'h3CFF;
        idx    = 0;
        budget = 400;
        while (idx < 16 && budget > 0) begin
            sdi_valid_i = 1'($urandom_range(0, 1));
            sdi_i       = bits[15-idx];
            if (sdi_valid_i && sdi_ready_o) idx++;
            step();
            budget--;
        end
        sdi_valid_i = 1'b0;
        chk("stall_budget", 16'(idx), 16'd16);
        chk("stall_early",  16'(done_cnt), 16'd0);
        chk("stall_commit", 16'(done_o), 16'h1);
        chk("stall_d",      16'(d_o), 16'h003C);
        chk("stall_dis",    16'(dis_o), 16'h0000);
        step();
        step();
        chk("stall_bank", 16'(bank_q), 16'h003C);
        chk("stall_once", 16'(done_cnt), 16'd1);

        // ---------------- restart and ignore ----------------
        done_cnt = 0;
        start_i  = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sdi_i       = 1'b0;
            sdi_valid_i = 1'b1;
            step();
        end
        // restart with a concurrent valid bit that must be discarded
        sdi_i = 1'b1;
        frame(8'h81, 8'hFF);
        chk("rs_done", 16'(done_o), 16'h1);
        chk("rs_d",    16'(d_o), 16'h0081);
        chk("rs_dis",  16'(dis_o), 16'h0000);
        start_i = 1'b1;   // during COMMIT: must be ignored
        step();
        start_i = 1'b0;
        chk("rs_ign_busy", 16'(busy_o), 16'h0);
        step();
        chk("rs_ign_busy2", 16'(busy_o), 16'h0);
        chk("rs_bank",      16'(bank_q), 16'h0081);
        chk("rs_dcnt",      16'(done_cnt), 16'd1);

        // ---------------- zero mask ----------------
        done_cnt = 0;
        dis_seen = '1;
        start_i  = 1'b1;
        step();
        start_i = 1'b0;
        bits = 16'hFF00;
        for (int i = 15; i >= 0; i--) begin
            sdi_i       = bits[i];
            sdi_valid_i = 1'b1;
            dis_seen    = dis_seen & dis_o;
            step();
        end
        sdi_valid_i = 1'b0;
        dis_seen    = dis_seen & dis_o;
        chk("zm_done", 16'(done_o), 16'h1);
        chk("zm_dis",  16'(dis_seen), 16'h00FF);
        chk("zm_d",    16'(d_o), 16'h00FF);
        step();
        chk("zm_bank", 16'(bank_q), 16'h0081);
        chk("zm_dcnt", 16'(done_cnt), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // global time limit
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/led_frame_loader.md
# led_frame_loader

Serial-to-parallel write controller feeding a bank of `dff_dis_led` cells. It receives a frame of WIDTH data bits followed by WIDTH mask bits over a one-bit valid/ready stream. It then drives the bank's per-bit `d_i` and `dis_i` lines so that exactly one clock edge writes the masked bits; unmasked LEDs keep their state. It sits directly upstream of the LED register bank on the same clock.

## Interface
- `WIDTH`, default 8: number of LED cells driven. Legal range is WIDTH >= 2. Bit counter width is $clog2(WIDTH).
- `clk_i` in 1: single clock, shared with the downstream `dff_dis_led` bank.
- `rst_i` in 1: reset, synchronous and active-high.
- `start_i` in 1: begin (or restart) a frame.
- `sdi_i` in 1: serial data bit.
- `sdi_valid_i` in 1: `sdi_i` is valid this cycle.
- `sdi_ready_o` out 1: loader accepts a bit this cycle.
- `busy_o` out 1: state is not IDLE.
- `done_o` out 1: single-cycle pulse during COMMIT.
- `d_o` out WIDTH: data to the bank; bit i goes to cell i `d_i`.
- `dis_o` out WIDTH: per-cell disable; bit i goes to cell i `dis_i`. 1 = hold, 0 = load.

## Operation
- Reset values, applied on the rising edge with `rst_i`=1:
  - state = IDLE, bit counter = 0.
  - data register = 0, mask register = 0, so `d_o` = 0.
  - `dis_o` = all 1s; `sdi_ready_o`, `busy_o`, `done_o` = 0.
  - `rst_i` in any state, including mid-frame or COMMIT, aborts immediately. No partial commit occurs.
- States: IDLE, DATA, MASK, COMMIT.
- Outputs per state:
  - `sdi_ready_o` = 1 only in DATA and MASK.
  - `busy_o` = 1 in DATA, MASK and COMMIT.
- A bit is accepted when `sdi_valid_i` & `sdi_ready_o`.
- IDLE -> DATA when `start_i`=1. Counter cleared.
- DATA behaviour:
  - Each accepted bit shifts MSB-first: data <= {data[WIDTH-2:0], sdi_i}. The counter increments.
  - When the accepted bit has counter == WIDTH-1: go to MASK and clear the counter.
- MASK: same as DATA, but shifts into the mask register. After WIDTH accepted bits, go to COMMIT.
- COMMIT lasts exactly one cycle:
  - `dis_o` = ~mask, `done_o` = 1, `sdi_ready_o` = 0.
  - Next state is IDLE unconditionally.
- Outside COMMIT, `dis_o` = all 1s.
- `d_o` continuously reflects the data register. It may change while shifting; this is harmless because `dis_o` is all 1s then.
- `start_i` in DATA or MASK restarts the frame:
  - Next state is DATA, counter cleared.
  - A bit accepted in the same cycle is discarded.
  - The data and mask registers keep their old contents until overwritten by shifting.
- `start_i` in COMMIT is ignored. It is not queued.
- `sdi_valid_i` with `sdi_ready_o`=0 is ignored; the bit is dropped.
- Idle cycles (`sdi_valid_i`=0) within DATA/MASK stall indefinitely, with no timeout.
- All-zero mask: COMMIT still occurs, `done_o` still pulses, and `dis_o` stays all 1s.

## Timing
- All outputs are registered or decoded from state registers only. There are no combinational paths from inputs to outputs.
- `start_i` sampled at edge k: DATA from cycle k+1, and `sdi_ready_o`=1 in cycle k+1.
- Minimum frame, with valid held high: 1 start cycle, then 2·WIDTH accept cycles, then 1 COMMIT cycle.
- WIDTH=8, start in cycle 0:
  - Data bits accepted in cycles 1–8, mask bits in cycles 9–16.
  - COMMIT in cycle 17; IDLE again in cycle 18.
  - The bank's `q_o` updates at the edge ending cycle 17.
- `start_i` held high across the COMMIT->IDLE boundary starts a new frame at the IDLE cycle. Back-to-back throughput is therefore 2·WIDTH+2 cycles per frame.

## Test plan
- Reset: assert `rst_i` for 2 cycles during MASK. Required afterwards:
  - `dis_o`=8'hFF, `d_o`=0, `busy_o`=0, `sdi_ready_o`=0.
  - No `done_o` pulse.
- Full write, WIDTH=8: start, then data 8'hA5 MSB-first, then mask 8'hFF with valid held high. Required:
  - COMMIT in cycle 17 with `dis_o`=8'h00, `d_o`=8'hA5, `done_o`=1 for one cycle.
  - Bank reads 8'hA5 in cycle 18.
- Partial mask: bank preloaded with 8'h00; frame with data 8'hFF, mask 8'h0F. Required:
  - `dis_o`=8'hF0 in COMMIT.
  - Bank reads 8'h0F afterwards.
- Stalls: randomly deassert `sdi_valid_i` (~50%) during a frame with data 8'h3C, mask 8'hFF. Required:
  - The counter advances only on accepted bits.
  - Committed value is 8'h3C; `done_o` fires exactly once.
- Restart and ignore: assert `start_i` after 5 data bits, then send a full frame with data 8'h81, mask 8'hFF. Required:
  - Commit of 8'h81 only.
  - `start_i` asserted during COMMIT does not set `busy_o` in the following cycle.
- Zero mask: frame with data 8'hFF, mask 8'h00. Required:
  - `done_o` pulses and `dis_o` stays 8'hFF throughout.
  - Bank contents unchanged.
